pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generation stage, directly upstream of instruction fetch.
- Produces the PC that fetch presents to instruction memory.
- Applies sequential increment, stall hold, branch/jump redirects, trap entry, halt/resume and misaligned-target detection.
- Emits a one-cycle flush pulse so fetch/decode kill the in-flight instruction after any control-flow change.

Parameters:
- DATA_WIDTH, 32, width of PC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0010, PC loaded on misaligned redirect target.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- stall  input  1  hold PC (downstream not ready).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  DATA_WIDTH  new PC for redirect.
- trap_valid  input  1  trap entry request.
- trap_vector  input  DATA_WIDTH  trap handler address.
- halt_req  input  1  request halt (wfi/ebreak).
- resume  input  1  leave HALTED.
- pc_out  output  DATA_WIDTH  current PC to fetch.
- pc_valid  output  1  pc_out is a live fetch request.
- pc_plus4  output  DATA_WIDTH  pc_out+4, combinational (link value).
- fetch_flush  output  1  1-cycle pulse: discard in-flight instruction.
- halted  output  1  state == HALTED.
- misaligned_exc  output  1  1-cycle pulse: redirect target not word-aligned.
- misaligned_addr  output  DATA_WIDTH  offending target, held until next exception.

Behaviour:
- Reset (async, any time, including mid-redirect or while HALTED):
  - State BOOT, pc_out=RESET_VECTOR, pc_valid=0.
  - fetch_flush=0, halted=0, misaligned_exc=0, misaligned_addr=0.
- All outputs are registered except pc_plus4.
- Arithmetic: pc_plus4 = pc_out+4 mod 2^DATA_WIDTH; 0xFFFF_FFFC wraps to 0x0000_0000, no flag.
- States:
  - BOOT: pc_valid=0; all inputs ignored; next edge -> RUN with pc_out unchanged (RESET_VECTOR).
  - RUN: pc_valid=1. Per edge, first match in priority order:
    1. trap_valid: pc_out <= {trap_vector[DW-1:2],2'b00}; fetch_flush<=1.
    2. redirect_valid, target[1:0]==0: pc_out<=redirect_target; fetch_flush<=1.
    3. redirect_valid, target[1:0]!=0: pc_out<=EXC_VECTOR; misaligned_exc<=1; misaligned_addr<=redirect_target; fetch_flush<=1.
    4. halt_req: pc_out<=pc_plus4 (halting instruction retires); -> HALTED.
    5. stall: pc_out holds; pc_valid stays 1.
    6. else: pc_out<=pc_plus4.
    - Cases 1-3 with halt_req also asserted: the PC update applies, and state -> HALTED.
    - stall never blocks a trap or redirect.
  - HALTED: pc_valid=0, halted=1, pc_out holds.
    - redirect_valid, stall and halt_req are ignored.
    - trap_valid: pc_out <= aligned trap_vector, fetch_flush<=1, -> RUN. Takes priority over resume.
    - resume: -> RUN, pc_out unchanged, no flush.
- fetch_flush and misaligned_exc are pulses: forced 0 on every edge where they are not set.
- Latency: a redirect or trap sampled at edge N appears on pc_out and fetch_flush after edge N. Fetch sees the new address in cycle N+1.

Test Plan:
- Reset release with RESET_VECTOR=0: pc_out=0 and pc_valid=0 for 1 cycle, then pc_out=0,4,8,C on consecutive cycles with pc_valid=1.
- At pc=0x8, stall high 3 cycles: pc_out stays 0x8 and pc_valid stays 1; after stall drops, pc_out goes 0xC then 0x10.
- At pc=0x20, redirect_valid=1 with target 0x100, stall=1 in the same cycle: next cycle pc_out=0x100 and fetch_flush=1 for exactly 1 cycle, then pc_out=0x104.
- redirect_target=0x102: next cycle pc_out=0x10, misaligned_exc=1 for 1 cycle, misaligned_addr=0x102 (held); with trap_valid=1 (trap_vector=0x203) in the same cycle instead, pc_out=0x200 and misaligned_exc=0.
- halt_req at pc=0x40: next cycle halted=1, pc_valid=0, pc_out=0x44; redirect ignored while halted; resume -> pc_valid=1 at 0x44, then 0x48.
- PC preset to 0xFFFF_FFFC via redirect: next increment gives pc_out=0x0; async rst asserted mid-cycle while HALTED gives immediate pc_out=RESET_VECTOR, halted=0.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generation stage feeding instruction fetch.
// Latency: a redirect, trap or halt sampled at an edge shows on pc_out after that edge; pc_plus4 is combinational.
// Backpressure: stall holds the PC in RUN, but never blocks a trap or redirect.
module pc_gen #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_vector,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  pc_valid,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  fetch_flush,
  output logic                  halted,
  output logic                  misaligned_exc,
  output logic [DATA_WIDTH-1:0] misaligned_addr
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  // Trap handlers are always entered on a word boundary.
  logic [DATA_WIDTH-1:0] trap_aligned;
  assign trap_aligned = {trap_vector[DATA_WIDTH-1:2], 2'b00};

  // Link value; wraps silently at the top of the address space.
  assign pc_plus4 = pc_out + DATA_WIDTH'(4);

  // State machine with all outputs registered; pulses default low every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= BOOT;
      pc_out          <= RESET_VECTOR;
      pc_valid        <= 1'b0;
      fetch_flush     <= 1'b0;
      halted          <= 1'b0;
      misaligned_exc  <= 1'b0;
      misaligned_addr <= '0;
    end else begin
      fetch_flush    <= 1'b0;
      misaligned_exc <= 1'b0;
      unique case (state)
        BOOT: begin
          // First fetch is issued from the reset vector itself.
          state    <= RUN;
          pc_valid <= 1'b1;
          halted   <= 1'b0;
        end
        RUN: begin
          if (trap_valid) begin
            pc_out      <= trap_aligned;
            fetch_flush <= 1'b1;
          end else if (redirect_valid && (redirect_target[1:0] == 2'b00)) begin
            pc_out      <= redirect_target;
            fetch_flush <= 1'b1;
          end else if (redirect_valid) begin
            pc_out          <= EXC_VECTOR;
            misaligned_exc  <= 1'b1;
            misaligned_addr <= redirect_target;
            fetch_flush     <= 1'b1;
          end else if (halt_req) begin
            // The halting instruction retires, so step past it.
            pc_out <= pc_plus4;
          end else if (!stall) begin
            pc_out <= pc_plus4;
          end
          // A halt request combined with a control-flow change still halts,
          // after the PC update above has been taken.
          if (halt_req) begin
            state    <= HALTED;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end
        end
        HALTED: begin
          // Only a trap or resume wakes the core; a trap wins over resume.
          if (trap_valid) begin
            pc_out      <= trap_aligned;
            fetch_flush <= 1'b1;
            state       <= RUN;
            pc_valid    <= 1'b1;
            halted      <= 1'b0;
          end else if (resume) begin
            state    <= RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          pc_out   <= RESET_VECTOR;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, increment, stall, redirects, traps, halt, wrap.
// Steps are sampled 1 time unit after each rising edge.
// Inputs change only right after sampling, well clear of the next edge.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] pc_plus4;
  logic        fetch_flush;
  logic        halted;
  logic        misaligned_exc;
  logic [31:0] misaligned_addr;

  int total;
  int passed;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .pc_plus4        (pc_plus4),
    .fetch_flush     (fetch_flush),
    .halted          (halted),
    .misaligned_exc  (misaligned_exc),
    .misaligned_addr (misaligned_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot of every registered output plus the link value.
  task automatic check_all(input string tag, input logic [31:0] pc, input logic vld,
                           input logic flush, input logic hlt, input logic mexc,
                           input logic [31:0] maddr);
    check({tag, ".pc_out"}, pc_out, pc);
    check({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, vld});
    check({tag, ".fetch_flush"}, {31'd0, fetch_flush}, {31'd0, flush});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
    check({tag, ".misaligned_exc"}, {31'd0, misaligned_exc}, {31'd0, mexc});
    check({tag, ".misaligned_addr"}, misaligned_addr, maddr);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    trap_valid = 1'b0;
    trap_vector = '0;
    halt_req = 1'b0;
    resume = 1'b0;

    // Reset state, held across an edge.
    step();
    check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("reset.pc_plus4", pc_plus4, 32'h4);
    rst = 1'b0;
    #2;
    check_all("boot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Boot cycle, then sequential fetch 0,4,8.
    step();
    check_all("run0", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("run4.pc_out", pc_out, 32'h4);
    step();
    check("run8.pc_out", pc_out, 32'h8);
    check("run8.pc_plus4", pc_plus4, 32'hC);

    // Stall at 0x8 for three edges.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc_out", pc_out, 32'h8);
      check("stall.pc_valid", {31'd0, pc_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    check("unstall1.pc_out", pc_out, 32'hC);
    step();
    check("unstall2.pc_out", pc_out, 32'h10);

    // Move to 0x20, then redirect to 0x100 while stalled.
    redirect_valid = 1'b1;
    redirect_target = 32'h20;
    step();
    check_all("redir20", 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    redirect_target = 32'h100;
    stall = 1'b1;
    step();
    check_all("redir100", 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    redirect_valid = 1'b0;
    stall = 1'b0;
    step();
    check_all("after100", 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    step();
    check_all("misal", 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h102);
    redirect_valid = 1'b0;
    step();
    check_all("misal_after", 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102);

    // Trap beats the same misaligned redirect; vector gets aligned.
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    trap_valid = 1'b1;
    trap_vector = 32'h203;
    step();
    check_all("trap", 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102);
    redirect_valid = 1'b0;
    trap_valid = 1'b0;
    step();
    check_all("trap_after", 32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102);

    // Halt at 0x40.
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    step();
    check("to40.pc_out", pc_out, 32'h40);
    redirect_valid = 1'b0;
    halt_req = 1'b1;
    step();
    check_all("halt", 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102);
    halt_req = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    step();
    check_all("halt_redir", 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102);
    redirect_valid = 1'b0;
    resume = 1'b1;
    step();
    check_all("resume", 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102);
    resume = 1'b0;
    step();
    check("resume_next.pc_out", pc_out, 32'h48);

    // Wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    check("top.pc_out", pc_out, 32'hFFFF_FFFC);
    check("top.pc_plus4", pc_plus4, 32'h0);
    redirect_valid = 1'b0;
    step();
    check_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102);

    // Redirect with halt_req: the redirect lands and the core halts.
    redirect_valid = 1'b1;
    redirect_target = 32'h500;
    halt_req = 1'b1;
    step();
    check_all("redir_halt", 32'h500, 1'b0, 1'b1, 1'b1, 1'b0, 32'h102);
    redirect_valid = 1'b0;
    halt_req = 1'b0;

    // Trap while halted wins over resume.
    trap_valid = 1'b1;
    trap_vector = 32'h81;
    resume = 1'b1;
    step();
    check_all("halt_trap", 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 32'h102);
    trap_valid = 1'b0;
    resume = 1'b0;

    // Halt again, then assert reset asynchronously mid-cycle.
    halt_req = 1'b1;
    step();
    check("halt2.halted", {31'd0, halted}, 32'd1);
    check("halt2.pc_out", pc_out, 32'h84);
    halt_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
